// File: rtl/rf_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rf_exec_unit                                                  |
// | Brief    : Execute/writeback stage for reg_file: single-cycle ALU ops    |
// |            plus an iterative shift-add multiply, one write port.         |
// |            Optional forwarding enabled by macro RF_EXEC_BYPASS_EN.       |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module rf_exec_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr1,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr2,
    input  logic [DATA_WIDTH-1:0] rf_rd_data1,
    input  logic [DATA_WIDTH-1:0] rf_rd_data2,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  rf_wr_en,
    output logic                  busy
);

    localparam int c_SHAMT_W = $clog2(DATA_WIDTH);
    localparam int c_CNT_W   = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_SLL = 3'd5;
    localparam logic [2:0] c_OP_LI  = 3'd6;
    localparam logic [2:0] c_OP_MUL = 3'd7;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_MUL  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [2:0]            r_ex_op;
    logic [ADDR_WIDTH-1:0] r_ex_rd;
    logic [DATA_WIDTH-1:0] r_ex_a;
    logic [DATA_WIDTH-1:0] r_ex_b;
    logic [DATA_WIDTH-1:0] r_ex_imm;
    logic [c_CNT_W-1:0]    r_mul_cnt;
    logic [DATA_WIDTH-1:0] r_mul_acc;

    logic                  w_accept;
    logic                  w_ex_live;
    logic [DATA_WIDTH-1:0] w_opa;
    logic [DATA_WIDTH-1:0] w_opb;
    logic [DATA_WIDTH-1:0] w_ex_result;
    logic [DATA_WIDTH-1:0] w_mul_acc_nxt;
    logic                  w_mul_done;

    assign rf_rd_addr1 = in_rs1;
    assign rf_rd_addr2 = in_rs2;
    assign w_ex_live   = (r_state == c_ST_EXEC);
    assign w_accept    = in_valid && in_ready;
    assign w_mul_done  = (r_state == c_ST_MUL) && (r_mul_cnt == c_CNT_LAST);
    assign busy        = (r_state != c_ST_IDLE) || rf_wr_en;

`ifdef RF_EXEC_BYPASS_EN
    // Youngest producer wins: EX result ahead of the pending WB write.
    always_comb begin
        w_opa = rf_rd_data1;
        w_opb = rf_rd_data2;
        if (w_ex_live && (r_ex_rd == in_rs1)) begin
            w_opa = w_ex_result;
        end else if (rf_wr_en && (rf_wr_addr == in_rs1)) begin
            w_opa = rf_wr_data;
        end
        if (w_ex_live && (r_ex_rd == in_rs2)) begin
            w_opb = w_ex_result;
        end else if (rf_wr_en && (rf_wr_addr == in_rs2)) begin
            w_opb = rf_wr_data;
        end
    end

    assign in_ready = (r_state != c_ST_MUL);
`else
    logic w_hazard;

    assign w_opa = rf_rd_data1;
    assign w_opb = rf_rd_data2;

    // LI reads no operands, so it never waits on an in-flight producer.
    assign w_hazard = (in_op != c_OP_LI) &&
                      ((w_ex_live && ((r_ex_rd == in_rs1) || (r_ex_rd == in_rs2))) ||
                       (rf_wr_en  && ((rf_wr_addr == in_rs1) || (rf_wr_addr == in_rs2))));

    assign in_ready = (r_state != c_ST_MUL) && !(in_valid && w_hazard);
`endif

    always_comb begin
        w_ex_result = '0;
        case (r_ex_op)
            c_OP_ADD: w_ex_result = r_ex_a + r_ex_b;
            c_OP_SUB: w_ex_result = r_ex_a - r_ex_b;
            c_OP_AND: w_ex_result = r_ex_a & r_ex_b;
            c_OP_OR:  w_ex_result = r_ex_a | r_ex_b;
            c_OP_XOR: w_ex_result = r_ex_a ^ r_ex_b;
            c_OP_SLL: w_ex_result = r_ex_a << r_ex_b[c_SHAMT_W-1:0];
            c_OP_LI:  w_ex_result = r_ex_imm;
            default:  w_ex_result = '0;
        endcase
    end

    assign w_mul_acc_nxt = r_ex_b[0] ? (r_mul_acc + r_ex_a) : r_mul_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_EXEC: begin
                if (w_accept) begin
                    w_state_nxt = (in_op == c_OP_MUL) ? c_ST_MUL : c_ST_EXEC;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_MUL: begin
                if (w_mul_done) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // EX register; A/B double as the multiplicand/multiplier shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_op   <= c_OP_ADD;
            r_ex_rd   <= '0;
            r_ex_a    <= '0;
            r_ex_b    <= '0;
            r_ex_imm  <= '0;
            r_mul_cnt <= '0;
            r_mul_acc <= '0;
        end else if (w_accept) begin
            r_ex_op   <= in_op;
            r_ex_rd   <= in_rd;
            r_ex_a    <= w_opa;
            r_ex_b    <= w_opb;
            r_ex_imm  <= in_imm;
            r_mul_cnt <= c_CNT_INIT;
            r_mul_acc <= '0;
        end else if (r_state == c_ST_MUL) begin
            r_mul_acc <= w_mul_acc_nxt;
            r_ex_a    <= r_ex_a << 1;
            r_ex_b    <= r_ex_b >> 1;
            r_mul_cnt <= r_mul_cnt - c_CNT_LAST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else if (w_ex_live) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= r_ex_rd;
            rf_wr_data <= w_ex_result;
        end else if (w_mul_done) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= r_ex_rd;
            rf_wr_data <= w_mul_acc_nxt;
        end else begin
            rf_wr_en   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rf_exec_unit                                               |
// | Brief    : Scoreboard bench for rf_exec_unit with a reg_file model and   |
// |            an architectural reference model of the instruction set.      |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_rf_exec_unit;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic [DW-1:0] in_imm;
    logic [AW-1:0] rf_rd_addr1, rf_rd_addr2;
    logic [DW-1:0] rf_rd_data1, rf_rd_data2;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic          rf_wr_en;
    logic          busy;

    rf_exec_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file the DUT drives: combinational reads, write on rising edge.
    logic [DW-1:0] rf [32] = '{default: '0};
    always @(posedge clk) if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    assign rf_rd_data1 = rf[rf_rd_addr1];
    assign rf_rd_data2 = rf[rf_rd_addr2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        int            lat;
        int            acc_cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] exp_regs [32];
    int            n_cmp = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference semantics straight from the instruction definitions.
    function automatic logic [DW-1:0] ref_op(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [DW-1:0] imm);
        longint unsigned p;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << (b % DW);
            3'd6: return imm;
            default: begin
                p = longint'(a) * longint'(b);
                return p[DW-1:0];
            end
        endcase
    endfunction

    // Monitor: every write the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rf_wr_en) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wb_unexpected: got write rd=%0d data=%h expected none", rf_wr_addr, rf_wr_data);
            end else begin
                e = sb.pop_front();
                chk("wb_addr", 64'(rf_wr_addr), 64'(e.rd));
                chk("wb_data", 64'(rf_wr_data), 64'(e.data));
                chk("wb_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns number of cycles spent waiting for in_ready.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [DW-1:0] imm, output int waits);
        exp_t e;
        in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.rd      = rd;
                e.data    = ref_op(op, exp_regs[rs1], exp_regs[rs2], imm);
                e.lat     = (op == 3'd7) ? DW : 1;
                e.acc_cyc = cyc + 1;
                sb.push_back(e);
                exp_regs[rd] = e.data;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                break;
            end
            waits++;
            if (waits > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL issue_timeout: got no accept after %0d cycles expected accept", waits);
                in_valid = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [DW-1:0] saved;
        logic [2:0]    rop;
        int            exp_stall;

        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;

        repeat (3) @(negedge clk);
        chk("rst_wr_en", 64'(rf_wr_en), 64'(0));
        chk("rst_wr_addr", 64'(rf_wr_addr), 64'(0));
        chk("rst_wr_data", 64'(rf_wr_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        in_rs1 = 5'd7; in_rs2 = 5'd9; #1;
        chk("rd_addr1", 64'(rf_rd_addr1), 64'(7));
        chk("rd_addr2", 64'(rf_rd_addr2), 64'(9));

        issue(3'd6, 0, 0, 3, 32'h12345678, w);
        idle(4);
        chk("r3_li", 64'(rf[3]), 64'h12345678);

        // Dependent ADD right behind two loads.
`ifdef RF_EXEC_BYPASS_EN
        exp_stall = 0;
`else
        exp_stall = 2;
`endif
        issue(3'd6, 0, 0, 1, 32'd5, w);
        issue(3'd6, 0, 0, 2, 32'd7, w);
        issue(3'd0, 1, 2, 4, 32'hDEAD_BEEF, w);
        chk("add_stall", 64'(w), 64'(exp_stall));
        idle(4);
        chk("r4_add", 64'(rf[4]), 64'h0000000C);

        issue(3'd6, 0, 0, 1, 32'hFFFFFFFF, w);
        issue(3'd6, 0, 0, 2, 32'd1, w);
        issue(3'd6, 0, 0, 11, 32'd1, w);
        issue(3'd0, 1, 2, 5, 32'd0, w);
        issue(3'd1, 2, 1, 6, 32'd0, w);
        issue(3'd6, 0, 0, 2, 32'd33, w);
        issue(3'd5, 11, 2, 7, 32'd0, w);
        idle(4);
        chk("r5_add_wrap", 64'(rf[5]), 64'h00000000);
        chk("r6_sub_wrap", 64'(rf[6]), 64'h00000002);
        chk("r7_sll_mod", 64'(rf[7]), 64'h00000002);

        issue(3'd6, 0, 0, 1, 32'h00010001, w);
        issue(3'd6, 0, 0, 2, 32'h00000003, w);
        issue(3'd7, 1, 2, 8, 32'd0, w);
        chk("mul_busy", 64'(busy), 64'(1));
        issue(3'd6, 0, 0, 12, 32'h0000_5A5A, w);
        chk("mul_stall", 64'(w), 64'(DW));
        idle(4);
        chk("r8_mul", 64'(rf[8]), 64'h00030003);

        // Reset in the middle of a multiply must drop it entirely.
        saved = exp_regs[8];
        issue(3'd7, 2, 2, 8, 32'd0, w);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 64'(rf_wr_en), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        sb.delete();
        exp_regs[8] = saved;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        idle(40);
        chk("midrst_r8_kept", 64'(rf[8]), 64'(saved));

        issue(3'd6, 0, 0, 0, 32'hAABBCCDD, w);
        issue(3'd4, 0, 0, 9, 32'd0, w);
        issue(3'd3, 0, 0, 10, 32'd0, w);
        idle(4);
        chk("r9_xor", 64'(rf[9]), 64'h00000000);
        chk("r10_or", 64'(rf[10]), 64'hAABBCCDD);

        for (int n = 0; n < 300; n++) begin
            rop = 3'($urandom_range(0, 7));
            issue(rop, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), $urandom, w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(50);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        for (int i = 0; i < 32; i++) chk("final_reg", 64'(rf[i]), 64'(exp_regs[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
